// File: rtl/ofdm_interleave.sv
// ofdm_interleave: transmit-side 802.11 OFDM bit interleaver.
// Coded bits are written one per strobe into a ping-pong pair of banks at
// their permuted position j; a full bank drains N_BPSC bits per beat.
// Optional HT 20 MHz single-stream support: define OFDM_INTERLEAVE_HT_EN.
module ofdm_interleave #(
`ifdef OFDM_INTERLEAVE_HT_EN
  parameter int unsigned MAX_CBPS = 312,
`else
  parameter int unsigned MAX_CBPS = 288,
`endif
  parameter int unsigned IDX_W    = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] rate,
  input  logic       in_bit,
  input  logic       input_strobe,
  output logic       in_ready,
  output logic [5:0] out_bits,
  output logic       output_strobe,
  input  logic       out_ready,
  output logic       sym_last
);

  // Modulation decode of the live rate input
  logic [2:0] dec_bpsc;
  logic       dec_ht;
  logic       unused_rate;

  // Write-side permutation counters
  logic             wb_q, wb_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] kcol_q, kcol_d;
  logic [IDX_W-1:0] colbase_q, colbase_d;
  logic [IDX_W-1:0] rowbase_q, rowbase_d;
  logic [1:0]       rowres_q, rowres_d;
  logic [1:0]       kres_q, kres_d;

  // Per-bank state
  logic [1:0]       full_q, full_d;
  logic [2:0]       bank_bpsc_q [2];
  logic [2:0]       bank_bpsc_d [2];
  logic [1:0]       bank_ht_q, bank_ht_d;

  // Read side
  logic             ib_q, ib_d;
  logic             rb_q, rb_d;
  logic [IDX_W-1:0] c_q, c_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [5:0]       ob_q, ob_d;
  logic             os_q, os_d;
  logic             sl_q, sl_d;

  logic [MAX_CBPS-1:0] mem_q [2];

  // Current write-symbol parameters
  logic             wr_first;
  logic [2:0]       cur_bpsc;
  logic             cur_ht;
  logic [1:0]       cur_s;
  logic [IDX_W-1:0] cur_nrow;
  logic [IDX_W-1:0] cur_ncol;
  logic [IDX_W-1:0] cur_ncbps;
  logic [1:0]       res_diff;
  logic [IDX_W-1:0] wr_j;
  logic             wr_accept;
  logic             wr_done;

  logic             beat_done;
  logic             rd_issue;
  logic [IDX_W-1:0] rd_lastc;
  logic [5:0]       gather;

  assign unused_rate = ^rate[7:2];

  assign in_ready      = ~full_q[wb_q];
  assign wr_accept     = enable & input_strobe & in_ready;
  assign beat_done     = enable & os_q & out_ready;
  assign rd_issue      = enable & full_q[ib_q] & (~os_q | out_ready);
  assign out_bits      = ob_q;
  assign output_strobe = os_q & enable;
  assign sym_last      = sl_q;

  // Decode bits per subcarrier from the rate code
  always_comb begin
    dec_ht = 1'b0;
    case (rate[1:0])
      2'b11:   dec_bpsc = 3'd1;
      2'b10:   dec_bpsc = 3'd2;
      2'b01:   dec_bpsc = 3'd4;
      default: dec_bpsc = 3'd6;
    endcase
`ifdef OFDM_INTERLEAVE_HT_EN
    if (rate[7]) begin
      dec_ht = 1'b1;
      case (rate[2:0])
        3'd0:       dec_bpsc = 3'd1;
        3'd1, 3'd2: dec_bpsc = 3'd2;
        3'd3, 3'd4: dec_bpsc = 3'd4;
        default:    dec_bpsc = 3'd6;
      endcase
    end
`endif
  end

  // Symbol geometry: live decode on k=0, latched bank values afterwards
  always_comb begin
    wr_first = (k_q == '0);
    cur_bpsc = wr_first ? dec_bpsc : bank_bpsc_q[wb_q];
    cur_ht   = wr_first ? dec_ht : bank_ht_q[wb_q];
    cur_ncol = cur_ht ? IDX_W'(13) : IDX_W'(16);
    case (cur_bpsc)
      3'd1: begin
        cur_s     = 2'd1;
        cur_nrow  = cur_ht ? IDX_W'(4) : IDX_W'(3);
        cur_ncbps = cur_ht ? IDX_W'(52) : IDX_W'(48);
      end
      3'd2: begin
        cur_s     = 2'd1;
        cur_nrow  = cur_ht ? IDX_W'(8) : IDX_W'(6);
        cur_ncbps = cur_ht ? IDX_W'(104) : IDX_W'(96);
      end
      3'd4: begin
        cur_s     = 2'd2;
        cur_nrow  = cur_ht ? IDX_W'(16) : IDX_W'(12);
        cur_ncbps = cur_ht ? IDX_W'(208) : IDX_W'(192);
      end
      default: begin
        cur_s     = 2'd3;
        cur_nrow  = cur_ht ? IDX_W'(24) : IDX_W'(18);
        cur_ncbps = cur_ht ? IDX_W'(312) : IDX_W'(288);
      end
    endcase
  end

  // Bank position j. N_ROW is a multiple of s, so i mod s equals the row
  // residue and s*floor(i/s) = colbase + rowbase; N_CBPS vanishes mod s.
  always_comb begin
    if (rowres_q >= kres_q) begin
      res_diff = rowres_q - kres_q;
    end else begin
      res_diff = rowres_q + cur_s - kres_q;
    end
    wr_j = colbase_q + rowbase_q + IDX_W'(res_diff);
  end

  // Write-side next state: advance column/row counters per accepted bit
  always_comb begin
    wb_d        = wb_q;
    k_d         = k_q;
    kcol_d      = kcol_q;
    colbase_d   = colbase_q;
    rowbase_d   = rowbase_q;
    rowres_d    = rowres_q;
    kres_d      = kres_q;
    bank_bpsc_d = bank_bpsc_q;
    bank_ht_d   = bank_ht_q;
    wr_done     = 1'b0;
    if (wr_accept) begin
      if (wr_first) begin
        bank_bpsc_d[wb_q] = dec_bpsc;
        bank_ht_d[wb_q]   = dec_ht;
      end
      if (k_q == cur_ncbps - 1'b1) begin
        wr_done   = 1'b1;
        wb_d      = ~wb_q;
        k_d       = '0;
        kcol_d    = '0;
        colbase_d = '0;
        rowbase_d = '0;
        rowres_d  = '0;
        kres_d    = '0;
      end else begin
        k_d = k_q + 1'b1;
        if (kcol_q == cur_ncol - 1'b1) begin
          kcol_d    = '0;
          colbase_d = '0;
          kres_d    = '0;
          if (rowres_q == cur_s - 1'b1) begin
            rowres_d  = '0;
            rowbase_d = rowbase_q + IDX_W'(cur_s);
          end else begin
            rowres_d = rowres_q + 1'b1;
          end
        end else begin
          kcol_d    = kcol_q + 1'b1;
          colbase_d = colbase_q + cur_nrow;
          kres_d    = (kres_q == cur_s - 1'b1) ? 2'd0 : kres_q + 1'b1;
        end
      end
    end
  end

  // Write-side registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_q        <= 1'b0;
      k_q         <= '0;
      kcol_q      <= '0;
      colbase_q   <= '0;
      rowbase_q   <= '0;
      rowres_q    <= '0;
      kres_q      <= '0;
      bank_bpsc_q <= '{3'd1, 3'd1};
      bank_ht_q   <= '0;
    end else begin
      wb_q        <= wb_d;
      k_q         <= k_d;
      kcol_q      <= kcol_d;
      colbase_q   <= colbase_d;
      rowbase_q   <= rowbase_d;
      rowres_q    <= rowres_d;
      kres_q      <= kres_d;
      bank_bpsc_q <= bank_bpsc_d;
      bank_ht_q   <= bank_ht_d;
    end
  end

  // Bit storage, written at the permuted position
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem_q[wb_q][wr_j] <= in_bit;
    end
  end

  // Gather the next beat's N_BPSC bits from the issuing bank
  always_comb begin
    gather = '0;
    for (int unsigned n = 0; n < 6; n++) begin
      if ((n < 32'(bank_bpsc_q[ib_q])) &&
          ((ptr_q + IDX_W'(n)) < IDX_W'(MAX_CBPS))) begin
        gather[n] = mem_q[ib_q][ptr_q + IDX_W'(n)];
      end
    end
  end

  // Read-side next state. The issue bank moves on as soon as its last beat
  // is loaded, while the bank is only freed once that beat is accepted; this
  // lets back-to-back banks stream without a bubble.
  always_comb begin
    ib_d     = ib_q;
    rb_d     = rb_q;
    c_d      = c_q;
    ptr_d    = ptr_q;
    ob_d     = ob_q;
    os_d     = os_q;
    sl_d     = sl_q;
    full_d   = full_q;
    rd_lastc = bank_ht_q[ib_q] ? IDX_W'(51) : IDX_W'(47);
    if (beat_done) begin
      os_d = 1'b0;
      ob_d = '0;
      sl_d = 1'b0;
      if (sl_q) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end
    end
    if (rd_issue) begin
      os_d = 1'b1;
      ob_d = gather;
      sl_d = (c_q == rd_lastc);
      if (c_q == rd_lastc) begin
        c_d   = '0;
        ptr_d = '0;
        ib_d  = ~ib_q;
      end else begin
        c_d   = c_q + 1'b1;
        ptr_d = ptr_q + IDX_W'(bank_bpsc_q[ib_q]);
      end
    end
    if (wr_done) begin
      full_d[wb_q] = 1'b1;
    end
  end

  // Read-side and bank-occupancy registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ib_q   <= 1'b0;
      rb_q   <= 1'b0;
      c_q    <= '0;
      ptr_q  <= '0;
      ob_q   <= '0;
      os_q   <= 1'b0;
      sl_q   <= 1'b0;
      full_q <= '0;
    end else begin
      ib_q   <= ib_d;
      rb_q   <= rb_d;
      c_q    <= c_d;
      ptr_q  <= ptr_d;
      ob_q   <= ob_d;
      os_q   <= os_d;
      sl_q   <= sl_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_ofdm_interleave.sv
// Self-checking bench for ofdm_interleave: directed vector table, corner
// sequences (latency, partial symbol, back-pressure, resets) and a random
// phase checked against an arithmetic model of the 802.11 permutation.
`timescale 1ns/1ps
module tb_ofdm_interleave;
`ifdef OFDM_INTERLEAVE_HT_EN
  localparam bit HT = 1'b1;
`else
  localparam bit HT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] rate;
  logic       in_bit;
  logic       input_strobe;
  logic       in_ready;
  logic [5:0] out_bits;
  logic       output_strobe;
  logic       out_ready;
  logic       sym_last;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] got_q [$];
  logic [6:0] exp_q [$];
  bit sym_bits [312];
  bit rnd_mode = 1'b0;

  typedef struct {
    logic [7:0] rate;
    int         kpos;
    int         nbits;
    int         nbeats;
    int         carrier;
    logic [5:0] bits;
  } vec_t;
  vec_t tbl [$];

  ofdm_interleave dut (
    .clock(clock), .reset(reset), .enable(enable), .rate(rate),
    .in_bit(in_bit), .input_strobe(input_strobe), .in_ready(in_ready),
    .out_bits(out_bits), .output_strobe(output_strobe),
    .out_ready(out_ready), .sym_last(sym_last)
  );

  initial forever #5 clock = ~clock;

  // Record every accepted beat, sampled on the falling edge
  initial forever begin
    @(negedge clock);
    if (reset && enable && output_strobe && out_ready)
      got_q.push_back({sym_last, out_bits});
  end

  // Random back-pressure and enable gaps during the random phase
  initial forever begin
    @(posedge clock);
    #1;
    if (rnd_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 9) != 0);
    end
  end

  initial begin
    #800000;
    miscompares++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
    end
  endtask

  function automatic bit is_ht(input logic [7:0] r);
    return HT && r[7];
  endfunction

  function automatic int bpsc_of(input logic [7:0] r);
    if (is_ht(r)) begin
      if (r[2:0] == 3'd0) return 1;
      if (r[2:0] <= 3'd2) return 2;
      if (r[2:0] <= 3'd4) return 4;
      return 6;
    end
    case (r[1:0])
      2'b11:   return 1;
      2'b10:   return 2;
      2'b01:   return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int nbits_of(input logic [7:0] r);
    return (is_ht(r) ? 52 : 48) * bpsc_of(r);
  endfunction

  // Reference: apply the two-step permutation to sym_bits, split into beats
  task automatic model_push(input logic [7:0] r);
    int b     = bpsc_of(r);
    int ncol  = is_ht(r) ? 13 : 16;
    int ncbps = nbits_of(r);
    int nrow  = ncbps / ncol;
    int s     = (b / 2 > 1) ? b / 2 : 1;
    int nc    = ncbps / b;
    bit inter [312];
    for (int k = 0; k < ncbps; k++) begin
      int i = nrow * (k % ncol) + k / ncol;
      int j = s * (i / s) + (i + ncbps - (k % ncol)) % s;
      inter[j] = sym_bits[k];
    end
    for (int c = 0; c < nc; c++) begin
      logic [6:0] e = '0;
      for (int n = 0; n < b; n++) e[n] = inter[c * b + n];
      e[6] = (c == nc - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_bits(input int n);
    for (int k = 0; k < n; k++) sym_bits[k] = bit'($urandom_range(0, 1));
  endtask

  // Feed sym_bits[from..to-1]; called just after a rising edge
  task automatic write_bits(input logic [7:0] r, input int from, input int to);
    int k = from;
    int guard = 0;
    bit acc;
    while (k < to && guard < 20000) begin
      guard++;
      if (rnd_mode && $urandom_range(0, 4) == 0) begin
        input_strobe = 1'b0;
      end else begin
        input_strobe = 1'b1;
        in_bit = sym_bits[k];
        rate = (k == 0 || !rnd_mode) ? r : 8'($urandom);
      end
      @(negedge clock);
      acc = input_strobe && in_ready && enable;
      @(posedge clock);
      #1;
      if (acc) k++;
    end
    input_strobe = 1'b0;
    if (k < to) chk("write_timeout", k, to);
  endtask

  task automatic wait_beats(input int n);
    int g = 0;
    while (got_q.size() < n && g < 20000) begin
      @(posedge clock);
      #1;
      g++;
    end
  endtask

  task automatic check_stream(input string name);
    wait_beats(exp_q.size());
    repeat (3) @(posedge clock);
    #1;
    chk({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(name, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] r;
    logic [6:0] e;
    reset = 1'b0; enable = 1'b1; rate = 8'h0B; in_bit = 1'b0;
    input_strobe = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_strobe", output_strobe, 0);
    chk("rst_bits", out_bits, 0);
    chk("rst_last", sym_last, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    tbl.push_back('{8'h0B, 1, 48, 48, 3, 6'b000001});
    tbl.push_back('{8'h0A, 1, 96, 48, 3, 6'b000001});
    tbl.push_back('{8'h0A, 16, 96, 48, 0, 6'b000010});
    tbl.push_back('{8'h09, 1, 192, 48, 3, 6'b000010});
    tbl.push_back('{8'h08, 1, 288, 48, 3, 6'b000100});
`ifdef OFDM_INTERLEAVE_HT_EN
    tbl.push_back('{8'h80, 1, 52, 52, 4, 6'b000001});
`endif
    for (int t = 0; t < tbl.size(); t++) begin
      for (int k = 0; k < 312; k++) sym_bits[k] = 1'b0;
      sym_bits[tbl[t].kpos] = 1'b1;
      write_bits(tbl[t].rate, 0, tbl[t].nbits);
      wait_beats(tbl[t].nbeats);
      repeat (3) @(posedge clock);
      #1;
      chk("dir_count", got_q.size(), tbl[t].nbeats);
      for (int c = 0; c < tbl[t].nbeats && c < got_q.size(); c++) begin
        e = {(c == tbl[t].nbeats - 1), (c == tbl[t].carrier) ? tbl[t].bits : 6'd0};
        chk("dir_beat", got_q[c], e);
      end
      got_q.delete();
    end

    // First strobe exactly two cycles after the last accepted bit
    rand_bits(48);
    model_push(8'h0B);
    write_bits(8'h0B, 0, 48);
    @(negedge clock);
    chk("lat_cycle1", output_strobe, 0);
    @(negedge clock);
    chk("lat_cycle2", output_strobe, 1);
    @(posedge clock);
    #1;
    check_stream("lat");

    // Partial symbol stays pending; rate change mid-symbol is ignored
    rand_bits(96);
    write_bits(8'h0A, 0, 30);
    repeat (100) @(posedge clock);
    #1;
    chk("partial_no_beats", got_q.size(), 0);
    chk("partial_in_ready", in_ready, 1);
    model_push(8'h0A);
    write_bits(8'h08, 30, 96);
    check_stream("partial");

    // Back-pressure across three BPSK symbols
    out_ready = 1'b0;
    rand_bits(48); model_push(8'h0B); write_bits(8'h0B, 0, 48);
    rand_bits(48); model_push(8'h0B); write_bits(8'h0B, 0, 48);
    @(negedge clock);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_strobe_held", output_strobe, 1);
    chk("bp_bits_held", out_bits, exp_q[0][5:0]);
    chk("bp_last_held", sym_last, 0);
    enable = 1'b0;
    #1;
    chk("en_low_strobe", output_strobe, 0);
    enable = 1'b1;
    @(posedge clock);
    #1;
    rand_bits(48);
    model_push(8'h0B);
    fork
      write_bits(8'h0B, 0, 48);
      begin
        repeat (4) @(posedge clock);
        #1;
        chk("bp_no_beats", got_q.size(), 0);
        out_ready = 1'b1;
        wait_beats(48);
        chk("bp_in_ready_back", in_ready, 1);
      end
    join
    check_stream("bp");

    // Reset during write at k=20
    rand_bits(48);
    write_bits(8'h0B, 0, 20);
    #2;
    reset = 1'b0;
    #1;
    chk("rstw_in_ready", in_ready, 1);
    chk("rstw_strobe", output_strobe, 0);
    chk("rstw_bits", out_bits, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    got_q.delete();
    rand_bits(288);
    model_push(8'h08);
    write_bits(8'h08, 0, 288);
    check_stream("post_rst_w");

    // Reset during drain
    for (int k = 0; k < 48; k++) sym_bits[k] = 1'b1;
    write_bits(8'h0B, 0, 48);
    repeat (8) @(posedge clock);
    #1;
    chk("drain_active", output_strobe, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("rstd_strobe", output_strobe, 0);
    chk("rstd_bits", out_bits, 0);
    chk("rstd_last", sym_last, 0);
    chk("rstd_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    got_q.delete();
    repeat (60) @(posedge clock);
    #1;
    chk("rstd_no_beats", got_q.size(), 0);
    rand_bits(96);
    model_push(8'h0A);
    write_bits(8'h0A, 0, 96);
    check_stream("post_rst_d");

    // Random rates, data, gaps, back-pressure and enable drops
    rnd_mode = 1'b1;
    for (int s = 0; s < 12; s++) begin
      r = 8'($urandom);
      rand_bits(nbits_of(r));
      model_push(r);
      write_bits(r, 0, nbits_of(r));
    end
    rnd_mode = 1'b0;
    @(posedge clock);
    #1;
    enable = 1'b1;
    out_ready = 1'b1;
    check_stream("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
